// File: rtl/resp_serializer_pkg.sv
// Shared types and constants for the response serializer.
package resp_serializer_pkg;

  // Serializer FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR_OP  = 3'd1,
    HDR_RSV = 3'd2,
    HDR_LSB = 3'd3,
    HDR_MSB = 3'd4,
    PAYLOAD = 3'd5
  } ser_state_t;

  // Header length in bytes: opcode, reserved, len LSB, len MSB
  localparam int unsigned HDR_BYTES = 4;

  // Opcodes shared with the request parser
  localparam logic [7:0] OP_ECHO = 8'h01;
  localparam logic [7:0] OP_ADD  = 8'h02;
  localparam logic [7:0] OP_MUL  = 8'h03;
  localparam logic [7:0] OP_DIV  = 8'h04;

endpackage

// File: rtl/resp_serializer_cnt.sv
// Up/down counter with synchronous clear; used as the payload byte index.
module resp_serializer_cnt #(
  parameter int unsigned WIDTH_P = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [WIDTH_P-1:0] count_o
);

  logic [WIDTH_P-1:0] count_q;

  // Clear has priority over counting
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      count_q <= '0;
    end else if (up_i && !down_i) begin
      count_q <= count_q + WIDTH_P'(1);
    end else if (down_i && !up_i) begin
      count_q <= count_q - WIDTH_P'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/resp_serializer.sv
// Latches one result and streams it as a response packet (header + payload
// LSB-first) on a byte-wide valid/ready interface.
module resp_serializer
  import resp_serializer_pkg::*;
#(
  parameter int unsigned MAX_BYTES_P = 8,
  parameter bit          HEADER_EN_P = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               opcode_i,
  input  logic [8*MAX_BYTES_P-1:0] result_i,
  input  logic [3:0]               nbytes_i,
  input  logic                     result_valid_i,
  output logic                     result_ready_o,
  output logic [7:0]               data_o,
  output logic                     valid_o,
  input  logic                     ready_i
);

  localparam int unsigned RES_W = 8 * MAX_BYTES_P;
  localparam int unsigned IDX_W = (MAX_BYTES_P > 1) ? $clog2(MAX_BYTES_P) : 1;
  localparam int unsigned NB_W  = $clog2(MAX_BYTES_P + 1);

  ser_state_t       state_q;
  logic [RES_W-1:0] result_q;
  logic [NB_W-1:0]  n_q;
  logic [7:0]       data_q;
  logic             valid_q;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] sel_idx;
  logic [7:0]       sel_byte;
  logic [NB_W-1:0]  n_d;
  logic [15:0]      len_d;
  logic             accept;
  logic             xfer;
  logic             last_byte;

  // Handshake decode and clamped payload length
  always_comb begin
    accept    = result_valid_i && (state_q == IDLE);
    xfer      = valid_q && ready_i;
    n_d       = (32'(nbytes_i) > MAX_BYTES_P) ? NB_W'(MAX_BYTES_P) : NB_W'(nbytes_i);
    len_d     = 16'(HDR_BYTES + 32'(n_q));
    last_byte = (NB_W'(idx) == (n_q - NB_W'(1)));
  end

  // Payload index: cleared on accept, advances on each non-final payload byte
  resp_serializer_cnt #(
    .WIDTH_P (IDX_W)
  ) u_idx_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (accept),
    .up_i    (xfer && (state_q == PAYLOAD) && !last_byte),
    .down_i  (1'b0),
    .count_o (idx)
  );

  // Next payload byte to present: byte 0 leaving the header, idx+1 inside payload
  always_comb begin
    sel_idx  = (state_q == PAYLOAD) ? IDX_W'(idx + IDX_W'(1)) : '0;
    sel_byte = 8'h00;
    for (int unsigned k = 0; k < MAX_BYTES_P; k++) begin
      if (32'(sel_idx) == k) begin
        sel_byte = result_q[8*k +: 8];
      end
    end
  end

  // Packet FSM; data_q always holds the byte currently offered downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      n_q      <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            result_q <= result_i;
            n_q      <= n_d;
            if (HEADER_EN_P) begin
              state_q <= HDR_OP;
              data_q  <= opcode_i;
              valid_q <= 1'b1;
            end else if (n_d != '0) begin
              state_q <= PAYLOAD;
              data_q  <= result_i[7:0];
              valid_q <= 1'b1;
            end
          end
        end
        HDR_OP: begin
          if (xfer) begin
            state_q <= HDR_RSV;
            data_q  <= 8'h00;
          end
        end
        HDR_RSV: begin
          if (xfer) begin
            state_q <= HDR_LSB;
            data_q  <= len_d[7:0];
          end
        end
        HDR_LSB: begin
          if (xfer) begin
            state_q <= HDR_MSB;
            data_q  <= len_d[15:8];
          end
        end
        HDR_MSB: begin
          if (xfer) begin
            if (n_q != '0) begin
              state_q <= PAYLOAD;
              data_q  <= sel_byte;
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            if (last_byte) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end else begin
              data_q <= sel_byte;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign result_ready_o = (state_q == IDLE);
  assign data_o         = data_q;
  assign valid_o        = valid_q;

endmodule

// File: tb/tb_resp_serializer.sv
// Bench for resp_serializer: packet-level byte model, per-cycle compare,
// directed packets with literal expectations plus randomized traffic.
module tb_resp_serializer;
  import resp_serializer_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  opcode_i;
  logic [63:0] result_i;
  logic [3:0]  nbytes_i;
  logic        result_valid_i;
  logic        result_ready_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rmode    = 0;
  bit check_en = 0;

  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];
  int         log_cyc[$];

  logic       prev_stall = 1'b0;
  logic       prev_rst   = 1'b1;
  logic [7:0] prev_data  = 8'h00;

  resp_serializer #(.MAX_BYTES_P(8), .HEADER_EN_P(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .opcode_i       (opcode_i),
    .result_i       (result_i),
    .nbytes_i       (nbytes_i),
    .result_valid_i (result_valid_i),
    .result_ready_o (result_ready_o),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Packet-level model: a queue of the bytes still owed downstream
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      if (result_valid_i) begin
        int n;
        n = (nbytes_i > 8) ? 8 : int'(nbytes_i);
        exp_q.push_back(opcode_i);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'(4 + n));
        exp_q.push_back(8'h00);
        for (int k = 0; k < n; k++) exp_q.push_back(result_i[8*k +: 8]);
      end
    end else if (ready_i) begin
      void'(exp_q.pop_front());
    end
  end

  // Per-cycle compare against the model, mid-cycle
  always @(negedge clk) begin
    if (check_en) begin
      chk("result_ready", 64'(result_ready_o), 64'(exp_q.size() == 0));
      chk("valid", 64'(valid_o), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("data", 64'(data_o), 64'(exp_q[0]));
      if (prev_stall && !prev_rst) chk("stall_hold", 64'({valid_o, data_o}), 64'({1'b1, prev_data}));
    end
    prev_stall = valid_o && !ready_i;
    prev_data  = data_o;
    prev_rst   = rst;
    if (check_en && valid_o === 1'b1 && ready_i && !rst) begin
      log_q.push_back(data_o);
      log_cyc.push_back(cyc);
    end
  end

  // Downstream ready pattern
  initial begin
    int t;
    t = 0;
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       ready_i = 1'b1;
        1:       ready_i = ((t % 3) == 0);
        default: ready_i = ($urandom_range(3) != 0);
      endcase
      t++;
    end
  end

  task automatic send(input logic [7:0] op, input logic [63:0] r, input logic [3:0] nb);
    int w;
    w = 0;
    opcode_i = op;
    result_i = r;
    nbytes_i = nb;
    result_valid_i = 1'b1;
    while (!result_ready_o) begin
      @(posedge clk);
      #1;
      w++;
      if (w > 200) begin
        chk("accept_timeout", 64'(w), 64'(0));
        break;
      end
    end
    @(posedge clk);
    #1;
    result_valid_i = 1'b0;
    opcode_i = $urandom;
    result_i = {$urandom, $urandom};
    nbytes_i = 4'($urandom);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (exp_q.size() != 0 || !result_ready_o) begin
      @(posedge clk);
      #1;
      w++;
      if (w > 300) begin
        chk("idle_timeout", 64'(w), 64'(0));
        break;
      end
    end
  endtask

  task automatic cmp_log(input string name, input logic [7:0] ref_b[$]);
    chk({name, "_len"}, 64'(log_q.size()), 64'(ref_b.size()));
    for (int i = 0; i < ref_b.size() && i < log_q.size(); i++)
      chk(name, 64'(log_q[i]), 64'(ref_b[i]));
  endtask

  initial begin
    logic [7:0] ref_b[$];
    rst = 1'b1;
    result_valid_i = 1'b0;
    opcode_i = 8'h00;
    result_i = 64'h0;
    nbytes_i = 4'h0;

    // Reset held 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_ready", 64'(result_ready_o), 64'(1));
    chk("rst_data", 64'(data_o), 64'(0));
    check_en = 1;
    rst = 1'b0;

    // Back-to-back ADD packet, ready held high
    rmode = 0;
    log_q.delete(); log_cyc.delete();
    send(OP_ADD, 64'h0000_0000_1122_3344, 4'd4);
    wait_idle();
    ref_b = '{OP_ADD, 8'h00, 8'h08, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    cmp_log("add_bytes", ref_b);
    if (log_cyc.size() == 8) chk("add_consecutive", 64'(log_cyc[7] - log_cyc[0]), 64'(7));
    else chk("add_xfer_count", 64'(log_cyc.size()), 64'(8));

    // Same packet with a stalling sink
    rmode = 1;
    log_q.delete(); log_cyc.delete();
    send(OP_ADD, 64'h0000_0000_1122_3344, 4'd4);
    wait_idle();
    cmp_log("add_stall_bytes", ref_b);

    // Header-only packet
    rmode = 0;
    log_q.delete();
    send(OP_MUL, 64'hDEAD_BEEF_CAFE_F00D, 4'd0);
    wait_idle();
    ref_b = '{OP_MUL, 8'h00, 8'h04, 8'h00};
    cmp_log("n0_bytes", ref_b);

    // Oversized count clamps to 8
    log_q.delete();
    send(OP_DIV, 64'h0102_0304_0506_0708, 4'd12);
    wait_idle();
    ref_b = '{OP_DIV, 8'h00, 8'h0C, 8'h00, 8'h08, 8'h07, 8'h06, 8'h05,
              8'h04, 8'h03, 8'h02, 8'h01};
    cmp_log("clamp_bytes", ref_b);

    // Reset after the third byte, then a fresh 1-byte packet
    log_q.delete();
    send(OP_ADD, 64'h0000_0000_1122_3344, 4'd4);
    begin
      int w;
      w = 0;
      while (log_q.size() < 3 && w < 100) begin
        @(posedge clk);
        #1;
        w++;
      end
      chk("rst_mid_reach", 64'(log_q.size() >= 3), 64'(1));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_valid", 64'(valid_o), 64'(0));
    chk("rst_mid_ready", 64'(result_ready_o), 64'(1));
    log_q.delete();
    send(OP_ECHO, 64'h0000_0000_0000_00AB, 4'd1);
    wait_idle();
    ref_b = '{OP_ECHO, 8'h00, 8'h05, 8'h00, 8'hAB};
    cmp_log("post_rst_bytes", ref_b);

    // Randomized traffic against the model
    rmode = 2;
    for (int p = 0; p < 60; p++) begin
      send(8'($urandom), {$urandom, $urandom}, 4'($urandom));
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
